mem_bus_arbiter: RTL and testbench

- Shares the single memory bus (RAM/ROM/peripheral chip-select space) between two masters.
  - m0 is the CPU datapath.
  - m1 is a peripheral/DMA master.
- Per-master req/done handshake, round-robin on ties, registered and glitch-free bus outputs.
- Blocks illegal accesses (unused region, ROM writes) with an error flag.
- Sits between the masters and the chip-select decoder/RAM/ROM.

---
 rtl/mem_bus_defs.sv | 28 ++
 rtl/rr_arb2.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 208 ++++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_bus_defs.sv
// Shared encodings for the two-master memory bus arbiter.
package mem_bus_defs;

  // Chip-select space seen by the decoder
  localparam logic [1:0] CS_UNUSED = 2'd0;
  localparam logic [1:0] CS_RAM    = 2'd1;
  localparam logic [1:0] CS_ROM    = 2'd2;
  localparam logic [1:0] CS_PERIF  = 2'd3;

  // Arbiter FSM states
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DONE   = 2'd2;

  // Accesses that must never reach the bus: unused region and ROM writes
  function automatic logic is_illegal(input logic [1:0] cs, input logic we);
    logic bad;
    case (cs)
      CS_UNUSED: bad = 1'b1;
      CS_RAM:    bad = 1'b0;
      CS_ROM:    bad = we;
      CS_PERIF:  bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick; remembers the most recently granted master.
module rr_arb2 (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] i_req,
  input  logic       i_update,
  output logic [1:0] o_grant_c
);

  logic r_last;  // index of the master granted most recently

  // One-hot pick; on a tie the master that did not win last time goes first
  always_comb begin
    o_grant_c = 2'b00;
    case (i_req)
      2'b01:   o_grant_c = 2'b01;
      2'b10:   o_grant_c = 2'b10;
      2'b11:   o_grant_c = r_last ? 2'b01 : 2'b10;
      default: o_grant_c = 2'b00;
    endcase
  end

  // Record the winner whenever a grant is actually taken
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last <= 1'b1;
    end else if (i_update && (|o_grant_c)) begin
      r_last <= o_grant_c[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Shares one memory bus between the CPU (m0) and a DMA master (m1).
// IDLE -> ACCESS (WAIT_CYCLES) -> DONE; all bus outputs come from flops.
module mem_bus_arbiter
  import mem_bus_defs::*;
#(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [1:0]        m0_cs,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [1:0]        m0_size,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_done,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [1:0]        m1_cs,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [1:0]        m1_size,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic [1:0]        bus_cs,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_we,
  output logic              bus_re,
  output logic [1:0]        bus_size,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  output logic [1:0]        grant
);

  localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // State, counter and latched request fields
  logic [1:0]        r_state,   w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,     w_cnt_nxt;
  logic              r_we,      w_we_nxt;
  logic              r_illegal, w_illegal_nxt;

  // Registered outputs
  logic              r_m0_done,   w_m0_done_nxt;
  logic              r_m1_done,   w_m1_done_nxt;
  logic [DATA_W-1:0] r_rdata,     w_rdata_nxt;
  logic              r_err,       w_err_nxt;
  logic [1:0]        r_bus_cs,    w_bus_cs_nxt;
  logic [ADDR_W-1:0] r_bus_addr,  w_bus_addr_nxt;
  logic              r_bus_we,    w_bus_we_nxt;
  logic              r_bus_re,    w_bus_re_nxt;
  logic [1:0]        r_bus_size,  w_bus_size_nxt;
  logic [DATA_W-1:0] r_bus_wdata, w_bus_wdata_nxt;
  logic [1:0]        r_grant,     w_grant_nxt;

  // Arbitration and winner field mux
  logic [1:0]        w_req;
  logic [1:0]        w_arb_grant;
  logic              w_arb_update;
  logic              w_win_we;
  logic [1:0]        w_win_cs;
  logic [ADDR_W-1:0] w_win_addr;
  logic [1:0]        w_win_size;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_win_illegal;

  assign w_req        = {m1_req, m0_req};
  assign w_arb_update = (r_state == ST_IDLE);

  rr_arb2 u_rr_arb2 (
    .clock     (clock),
    .reset     (reset),
    .i_req     (w_req),
    .i_update  (w_arb_update),
    .o_grant_c (w_arb_grant)
  );

  assign w_win_we      = w_arb_grant[1] ? m1_we    : m0_we;
  assign w_win_cs      = w_arb_grant[1] ? m1_cs    : m0_cs;
  assign w_win_addr    = w_arb_grant[1] ? m1_addr  : m0_addr;
  assign w_win_size    = w_arb_grant[1] ? m1_size  : m0_size;
  assign w_win_wdata   = w_arb_grant[1] ? m1_wdata : m0_wdata;
  assign w_win_illegal = is_illegal(w_win_cs, w_win_we);

  // Next-state and next-output logic; bus is quiet unless a transfer is in ACCESS
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_we_nxt        = r_we;
    w_illegal_nxt   = r_illegal;
    w_m0_done_nxt   = 1'b0;
    w_m1_done_nxt   = 1'b0;
    w_rdata_nxt     = r_rdata;
    w_err_nxt       = 1'b0;
    w_bus_cs_nxt    = 2'b00;
    w_bus_addr_nxt  = '0;
    w_bus_we_nxt    = 1'b0;
    w_bus_re_nxt    = 1'b0;
    w_bus_size_nxt  = 2'b00;
    w_bus_wdata_nxt = '0;
    w_grant_nxt     = 2'b00;

    case (r_state)
      ST_IDLE: begin
        if (|w_req) begin
          w_state_nxt     = ST_ACCESS;
          w_cnt_nxt       = CNT_LOAD;
          w_we_nxt        = w_win_we;
          w_illegal_nxt   = w_win_illegal;
          w_grant_nxt     = w_arb_grant;
          w_bus_cs_nxt    = w_win_illegal ? CS_UNUSED : w_win_cs;
          w_bus_we_nxt    = !w_win_illegal && w_win_we;
          w_bus_re_nxt    = !w_win_illegal && !w_win_we;
          w_bus_addr_nxt  = w_win_addr;
          w_bus_size_nxt  = w_win_size;
          w_bus_wdata_nxt = w_win_wdata;
        end
      end

      ST_ACCESS: begin
        w_cnt_nxt = r_cnt - CNT_ONE;
        if (r_cnt == CNT_ONE) begin
          // Last access cycle: report completion, capture read data
          w_state_nxt   = ST_DONE;
          w_m0_done_nxt = r_grant[0];
          w_m1_done_nxt = r_grant[1];
          w_err_nxt     = r_illegal;
          if (r_illegal) begin
            w_rdata_nxt = '0;
          end else if (!r_we) begin
            w_rdata_nxt = bus_rdata;
          end
        end else begin
          w_grant_nxt     = r_grant;
          w_bus_cs_nxt    = r_bus_cs;
          w_bus_we_nxt    = r_bus_we;
          w_bus_re_nxt    = r_bus_re;
          w_bus_addr_nxt  = r_bus_addr;
          w_bus_size_nxt  = r_bus_size;
          w_bus_wdata_nxt = r_bus_wdata;
        end
      end

      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, latches and output flops; reset abandons any transfer at once
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_we        <= 1'b0;
      r_illegal   <= 1'b0;
      r_m0_done   <= 1'b0;
      r_m1_done   <= 1'b0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_bus_cs    <= 2'b00;
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_re    <= 1'b0;
      r_bus_size  <= 2'b00;
      r_bus_wdata <= '0;
      r_grant     <= 2'b00;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_we        <= w_we_nxt;
      r_illegal   <= w_illegal_nxt;
      r_m0_done   <= w_m0_done_nxt;
      r_m1_done   <= w_m1_done_nxt;
      r_rdata     <= w_rdata_nxt;
      r_err       <= w_err_nxt;
      r_bus_cs    <= w_bus_cs_nxt;
      r_bus_addr  <= w_bus_addr_nxt;
      r_bus_we    <= w_bus_we_nxt;
      r_bus_re    <= w_bus_re_nxt;
      r_bus_size  <= w_bus_size_nxt;
      r_bus_wdata <= w_bus_wdata_nxt;
      r_grant     <= w_grant_nxt;
    end
  end

  assign m0_done   = r_m0_done;
  assign m1_done   = r_m1_done;
  assign rdata     = r_rdata;
  assign err       = r_err;
  assign bus_cs    = r_bus_cs;
  assign bus_addr  = r_bus_addr;
  assign bus_we    = r_bus_we;
  assign bus_re    = r_bus_re;
  assign bus_size  = r_bus_size;
  assign bus_wdata = r_bus_wdata;
  assign grant     = r_grant;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Scoreboard bench for mem_bus_arbiter: one instance with WAIT_CYCLES=1,
// one with WAIT_CYCLES=3 for the mid-access reset scenario.
module tb_mem_bus_arbiter;

  localparam int W1 = 1;
  localparam int W3 = 3;
  localparam logic [63:0] PERIF_PAT = 64'hA5A5_5A5A_C3C3_3C3C;
  localparam logic [63:0] ROM_PAT   = 64'h0F0F_0F0F_F0F0_F0F0;
  localparam logic [63:0] D3_PAT    = 64'h3333_CCCC_3333_CCCC;
  localparam logic [63:0] W_DEAD    = 64'hDEAD_BEEF_0123_4567;
  localparam logic [63:0] W_1111    = 64'h1111_2222_3333_4444;

  typedef struct {
    logic [1:0]  grant;
    logic [1:0]  cs;
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [63:0] wdata;
    logic        err;
    logic [63:0] rdata;
  } exp_t;

  logic clock = 1'b0;
  logic rst1, rst3;

  // Master fields (shared by both instances), per-instance requests
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [1:0]  m0_cs, m0_size, m1_cs, m1_size;
  logic [31:0] m0_addr, m1_addr;
  logic [63:0] m0_wdata, m1_wdata;
  logic        d3_m0_req, d3_m1_req;

  // Instance 1 outputs
  logic        m0_done, m1_done, err, bus_we, bus_re;
  logic [63:0] rdata, bus_wdata, bus_rdata;
  logic [1:0]  bus_cs, bus_size, grant;
  logic [31:0] bus_addr;

  // Instance 3 outputs
  logic        d3_m0_done, d3_m1_done, d3_err, d3_bus_we, d3_bus_re;
  logic [63:0] d3_rdata, d3_bus_wdata, d3_bus_rdata;
  logic [1:0]  d3_bus_cs, d3_bus_size, d3_grant;
  logic [31:0] d3_bus_addr;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q1[$];
  exp_t q3[$];
  logic [63:0] ram [0:7];

  always #5 clock = ~clock;

  mem_bus_arbiter #(.WAIT_CYCLES(W1), .ADDR_W(32), .DATA_W(64)) u_dut1 (
    .clock(clock), .reset(rst1),
    .m0_req(m0_req), .m0_we(m0_we), .m0_cs(m0_cs), .m0_addr(m0_addr),
    .m0_size(m0_size), .m0_wdata(m0_wdata), .m0_done(m0_done),
    .m1_req(m1_req), .m1_we(m1_we), .m1_cs(m1_cs), .m1_addr(m1_addr),
    .m1_size(m1_size), .m1_wdata(m1_wdata), .m1_done(m1_done),
    .rdata(rdata), .err(err), .bus_cs(bus_cs), .bus_addr(bus_addr),
    .bus_we(bus_we), .bus_re(bus_re), .bus_size(bus_size),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .grant(grant)
  );

  mem_bus_arbiter #(.WAIT_CYCLES(W3), .ADDR_W(32), .DATA_W(64)) u_dut3 (
    .clock(clock), .reset(rst3),
    .m0_req(d3_m0_req), .m0_we(m0_we), .m0_cs(m0_cs), .m0_addr(m0_addr),
    .m0_size(m0_size), .m0_wdata(m0_wdata), .m0_done(d3_m0_done),
    .m1_req(d3_m1_req), .m1_we(m1_we), .m1_cs(m1_cs), .m1_addr(m1_addr),
    .m1_size(m1_size), .m1_wdata(m1_wdata), .m1_done(d3_m1_done),
    .rdata(d3_rdata), .err(d3_err), .bus_cs(d3_bus_cs), .bus_addr(d3_bus_addr),
    .bus_we(d3_bus_we), .bus_re(d3_bus_re), .bus_size(d3_bus_size),
    .bus_wdata(d3_bus_wdata), .bus_rdata(d3_bus_rdata), .grant(d3_grant)
  );

  // Small memory behind instance 1: 8-word RAM, fixed ROM and peripheral words
  always @(posedge clock or negedge rst1) begin
    if (!rst1) begin
      for (int i = 0; i < 8; i++) ram[i] <= '0;
    end else if (bus_we && bus_cs == 2'd1) begin
      ram[bus_addr[5:3]] <= bus_wdata;
    end
  end

  always_comb begin
    bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    if (bus_re) begin
      case (bus_cs)
        2'd1:    bus_rdata = ram[bus_addr[5:3]];
        2'd2:    bus_rdata = ROM_PAT;
        2'd3:    bus_rdata = PERIF_PAT;
        default: bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
      endcase
    end
  end

  assign d3_bus_rdata = D3_PAT;

  function automatic exp_t mk(input logic [1:0] g, input logic [1:0] cs,
                              input logic we, input logic re, input logic [31:0] addr,
                              input logic [1:0] size, input logic [63:0] wd,
                              input logic er, input logic [63:0] rd);
    exp_t e;
    e.grant = g; e.cs = cs; e.we = we; e.re = re; e.addr = addr;
    e.size = size; e.wdata = wd; e.err = er; e.rdata = rd;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, act, req);
    end
  endtask

  task automatic cmp_bus(input string tag, input exp_t e, input logic [1:0] g,
                         input logic [1:0] cs, input logic we, input logic re,
                         input logic [31:0] addr, input logic [1:0] size,
                         input logic [63:0] wd);
    chk({tag, ".grant"},    64'(g),    64'(e.grant));
    chk({tag, ".bus_cs"},   64'(cs),   64'(e.cs));
    chk({tag, ".bus_we"},   64'(we),   64'(e.we));
    chk({tag, ".bus_re"},   64'(re),   64'(e.re));
    chk({tag, ".bus_addr"}, 64'(addr), 64'(e.addr));
    chk({tag, ".bus_size"}, 64'(size), 64'(e.size));
    if (e.we) chk({tag, ".bus_wdata"}, wd, e.wdata);
  endtask

  task automatic cmp_done(input string tag, input exp_t e, input logic [1:0] dn,
                          input logic er, input logic [63:0] rd, input int cyc,
                          input int w);
    chk({tag, ".done"},          64'(dn),  64'(e.grant));
    chk({tag, ".err"},           64'(er),  64'(e.err));
    chk({tag, ".rdata"},         rd,       e.rdata);
    chk({tag, ".access_cycles"}, 64'(cyc), 64'(w));
  endtask

  // Monitor for instance 1
  initial begin : mon1
    int   cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (!rst1) begin
        cyc = 0;
      end else begin
        chk("d1.we_and_re", 64'(bus_we & bus_re), 64'(0));
        if (grant != 2'b00) begin
          cyc++;
          if (q1.size() == 0) chk("d1.unexpected_grant", 64'(grant), 64'(0));
          else cmp_bus("d1", q1[0], grant, bus_cs, bus_we, bus_re, bus_addr, bus_size, bus_wdata);
        end else begin
          chk("d1.idle_bus", 64'({bus_cs, bus_we, bus_re}), 64'(0));
        end
        if (m0_done || m1_done) begin
          if (q1.size() == 0) begin
            chk("d1.unexpected_done", 64'({m1_done, m0_done}), 64'(0));
          end else begin
            e = q1.pop_front();
            cmp_done("d1", e, {m1_done, m0_done}, err, rdata, cyc, W1);
          end
          cyc = 0;
        end
      end
    end
  end

  // Monitor for instance 3
  initial begin : mon3
    int   cyc;
    exp_t e;
    cyc = 0;
    forever begin
      @(negedge clock);
      if (!rst3) begin
        cyc = 0;
      end else begin
        chk("d3.we_and_re", 64'(d3_bus_we & d3_bus_re), 64'(0));
        if (d3_grant != 2'b00) begin
          cyc++;
          if (q3.size() == 0) chk("d3.unexpected_grant", 64'(d3_grant), 64'(0));
          else cmp_bus("d3", q3[0], d3_grant, d3_bus_cs, d3_bus_we, d3_bus_re,
                       d3_bus_addr, d3_bus_size, d3_bus_wdata);
        end else begin
          chk("d3.idle_bus", 64'({d3_bus_cs, d3_bus_we, d3_bus_re}), 64'(0));
        end
        if (d3_m0_done || d3_m1_done) begin
          if (q3.size() == 0) begin
            chk("d3.unexpected_done", 64'({d3_m1_done, d3_m0_done}), 64'(0));
          end else begin
            e = q3.pop_front();
            cmp_done("d3", e, {d3_m1_done, d3_m0_done}, d3_err, d3_rdata, cyc, W3);
          end
          cyc = 0;
        end
      end
    end
  end

  function automatic logic any_done(input int which);
    if (which == 1) return m0_done | m1_done;
    return d3_m0_done | d3_m1_done;
  endfunction

  // Wait (bounded) for a done pulse; returns just after the following edge
  task automatic wait_done(input string tag, input int which, output int k);
    k = 0;
    do begin
      @(negedge clock);
      k++;
    end while (!any_done(which) && k < 20);
    if (!any_done(which)) chk({tag, ".timeout"}, 64'(k), 64'(0));
    @(posedge clock);
    #1;
  endtask

  task automatic gap();
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin : stim
    int k;
    rst1 = 1'b0; rst3 = 1'b0;
    m0_req = 1'b0; m0_we = 1'b0; m0_cs = 2'd0; m0_addr = '0; m0_size = 2'd0; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_cs = 2'd0; m1_addr = '0; m1_size = 2'd0; m1_wdata = '0;
    d3_m0_req = 1'b0; d3_m1_req = 1'b0;

    // Reset held with m0 requesting a peripheral read
    m0_we = 1'b0; m0_cs = 2'd3; m0_addr = 32'h40; m0_size = 2'd3; m0_req = 1'b1;
    q1.push_back(mk(2'b01, 2'd3, 1'b0, 1'b1, 32'h40, 2'd3, '0, 1'b0, PERIF_PAT));
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst.done",  64'({m1_done, m0_done}), 64'(0));
    chk("rst.grant", 64'(grant), 64'(0));
    chk("rst.bus",   64'({bus_cs, bus_we, bus_re, bus_size}), 64'(0));
    chk("rst.addr",  64'(bus_addr), 64'(0));
    chk("rst.rdata", rdata, 64'(0));
    chk("rst.err",   64'(err), 64'(0));
    @(posedge clock); #1;
    rst1 = 1'b1;
    wait_done("rst_release", 1, k);
    chk("rst.done_latency", 64'(k), 64'(W1 + 2));
    m0_req = 1'b0;
    gap();

    // m0 write to RAM, then read back
    m0_we = 1'b1; m0_cs = 2'd1; m0_addr = 32'h10; m0_size = 2'd3; m0_wdata = W_DEAD;
    q1.push_back(mk(2'b01, 2'd1, 1'b1, 1'b0, 32'h10, 2'd3, W_DEAD, 1'b0, PERIF_PAT));
    m0_req = 1'b1;
    wait_done("wr", 1, k);
    m0_req = 1'b0;
    gap();
    m0_we = 1'b0;
    q1.push_back(mk(2'b01, 2'd1, 1'b0, 1'b1, 32'h10, 2'd3, '0, 1'b0, W_DEAD));
    m0_req = 1'b1;
    wait_done("rd", 1, k);
    m0_req = 1'b0;
    gap();

    // m1 write to ROM is blocked
    m1_we = 1'b1; m1_cs = 2'd2; m1_addr = 32'h20; m1_size = 2'd1; m1_wdata = 64'h0BAD_F00D_0BAD_F00D;
    q1.push_back(mk(2'b10, 2'd0, 1'b0, 1'b0, 32'h20, 2'd1, '0, 1'b1, 64'(0)));
    m1_req = 1'b1;
    wait_done("rom_wr", 1, k);
    m1_req = 1'b0;
    gap();

    // Both masters request continuously: m0, m1, m0, m1
    m0_we = 1'b0; m0_cs = 2'd1; m0_addr = 32'h10; m0_size = 2'd3;
    m1_we = 1'b1; m1_cs = 2'd1; m1_addr = 32'h18; m1_size = 2'd3; m1_wdata = W_1111;
    q1.push_back(mk(2'b01, 2'd1, 1'b0, 1'b1, 32'h10, 2'd3, '0,     1'b0, W_DEAD));
    q1.push_back(mk(2'b10, 2'd1, 1'b1, 1'b0, 32'h18, 2'd3, W_1111, 1'b0, W_DEAD));
    q1.push_back(mk(2'b01, 2'd1, 1'b0, 1'b1, 32'h18, 2'd3, '0,     1'b0, W_1111));
    q1.push_back(mk(2'b10, 2'd1, 1'b1, 1'b0, 32'h18, 2'd3, W_1111, 1'b0, W_1111));
    m0_req = 1'b1; m1_req = 1'b1;
    wait_done("rr0", 1, k);
    m0_addr = 32'h18;
    wait_done("rr1", 1, k);
    wait_done("rr2", 1, k);
    wait_done("rr3", 1, k);
    m0_req = 1'b0; m1_req = 1'b0;
    gap();

    // m0 read of the unused region
    m0_we = 1'b0; m0_cs = 2'd0; m0_addr = 32'h08; m0_size = 2'd0;
    q1.push_back(mk(2'b01, 2'd0, 1'b0, 1'b0, 32'h08, 2'd0, '0, 1'b1, 64'(0)));
    m0_req = 1'b1;
    wait_done("unused_rd", 1, k);
    m0_req = 1'b0;
    gap();

    // WAIT_CYCLES=3: reset during the second ACCESS cycle
    rst3 = 1'b1;
    @(posedge clock); #1;
    m0_we = 1'b0; m0_cs = 2'd1; m0_addr = 32'h10; m0_size = 2'd3;
    q3.push_back(mk(2'b01, 2'd1, 1'b0, 1'b1, 32'h10, 2'd3, '0, 1'b0, D3_PAT));
    d3_m0_req = 1'b1;
    @(posedge clock);
    @(posedge clock); #1;
    chk("d3.re_before_rst", 64'(d3_bus_re), 64'(1));
    #1 rst3 = 1'b0;
    #1;
    chk("d3.re_after_rst",    64'(d3_bus_re), 64'(0));
    chk("d3.grant_after_rst", 64'(d3_grant), 64'(0));
    chk("d3.cs_after_rst",    64'(d3_bus_cs), 64'(0));
    q3.delete();
    d3_m0_req = 1'b0;
    m1_we = 1'b0; m1_cs = 2'd3; m1_addr = 32'h30; m1_size = 2'd2;
    q3.push_back(mk(2'b10, 2'd3, 1'b0, 1'b1, 32'h30, 2'd2, '0, 1'b0, D3_PAT));
    d3_m1_req = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("d3.no_done_in_rst", 64'({d3_m1_done, d3_m0_done}), 64'(0));
      chk("d3.rdata_in_rst",   d3_rdata, 64'(0));
    end
    @(posedge clock); #1;
    rst3 = 1'b1;
    wait_done("d3_pending", 3, k);
    chk("d3.done_latency", 64'(k), 64'(5));
    d3_m1_req = 1'b0;
    gap();

    chk("d1.queue_drained", 64'(q1.size()), 64'(0));
    chk("d3.queue_drained", 64'(q3.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "bench did not complete");
  end

endmodule
